rng_slot_gen: RTL and testbench



---
 rtl/rng_slot_gen_if.sv | 35 +++
 rtl/rng_slot_gen.sv | 162 ++++++++++++++++
 tb/tb_rng_slot_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_slot_gen_if.sv
// Handshake and data bundle between the random/slot generator and its controller.
// The controller drives requests and slot commands; the generator returns results.
interface rng_slot_gen_if #(
  parameter int LFSR_W = 16,
  parameter int SLOT_W = 15
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed;
  logic              rn_req;
  logic [1:0]        rn_kind;
  logic              rn_busy;
  logic              rn_done;
  logic              rn1;
  logic [LFSR_W-1:0] rn16;
  logic [LFSR_W-1:0] handle;
  logic              slot_cmd_vld;
  logic [2:0]        slot_cmd;
  logic [3:0]        q_val;
  logic              divide_position;
  logic [3:0]        tag_state;
  logic [SLOT_W-1:0] slot_val;
  logic              slot_zero;

  modport master (
    output seed_load, seed, rn_req, rn_kind,
    output slot_cmd_vld, slot_cmd, q_val, divide_position, tag_state,
    input  rn_busy, rn_done, rn1, rn16, handle, slot_val, slot_zero
  );

  modport slave (
    input  seed_load, seed, rn_req, rn_kind,
    input  slot_cmd_vld, slot_cmd, q_val, divide_position, tag_state,
    output rn_busy, rn_done, rn1, rn16, handle, slot_val, slot_zero
  );
endinterface

// File: rtl/rng_slot_gen.sv
// LFSR-based random number generator (rn1/rn16/handle) plus the anti-collision
// slot counter that consumes the LFSR state and the last generated rn1 bit.
module rng_slot_gen #(
  parameter int          LFSR_W        = 16,
  parameter int          SLOT_W        = 15,
  parameter logic [31:0] SEED          = 32'h0000_29A1,
  parameter logic [3:0]  TAG_ARBITRATE = 4'd1,
  parameter logic [3:0]  TAG_REPLY     = 4'd2
) (
  input logic           DOUB_BLF,
  input logic           rst,
  rng_slot_gen_if.slave bus
);

  localparam logic [LFSR_W-1:0] SEED_VAL = SEED[LFSR_W-1:0];
  localparam logic [2:0] CMD_QUERY    = 3'b000;
  localparam logic [2:0] CMD_QUERYREP = 3'b001;
  localparam logic [2:0] CMD_DIVIDE   = 3'b010;
  localparam logic [2:0] CMD_DISPERSE = 3'b011;
  localparam logic [2:0] CMD_SHRINK   = 3'b100;
  localparam logic [1:0] KIND_RN1     = 2'b00;
  localparam logic [1:0] KIND_RN16    = 2'b01;
  localparam logic [1:0] KIND_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [1:0]        kind_q, kind_d;
  logic              rn1_q, rn1_d;
  logic [LFSR_W-1:0] rn16_q, rn16_d;
  logic [LFSR_W-1:0] handle_q, handle_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic [LFSR_W-1:0] lfsr_step;
  logic [SLOT_W-1:0] q_mask;
  logic [SLOT_W-1:0] slot_rn1;
  logic              is_arb;
  logic              is_rep;

  assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^lfsr_q[LFSR_W-1:LFSR_W-4]};

  // seed_load wins over everything and drops an in-flight generation silently
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    rn1_d    = rn1_q;
    rn16_d   = rn16_q;
    handle_d = handle_q;
    if (bus.seed_load) begin
      lfsr_d  = (bus.seed == '0) ? SEED_VAL : bus.seed;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rn_req && (bus.rn_kind != KIND_RSVD)) begin
            state_d = ST_GEN;
            kind_d  = bus.rn_kind;
            cnt_d   = (bus.rn_kind == KIND_RN1) ? 6'd1 : 6'(LFSR_W);
          end
        end
        ST_GEN: begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = ST_DONE;
            case (kind_q)
              KIND_RN1:  rn1_d    = lfsr_step[LFSR_W-1];
              KIND_RN16: rn16_d   = lfsr_step;
              default:   handle_d = lfsr_step;
            endcase
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Slot command decode; rn1_q here is the value registered before this edge
  always_comb begin
    slot_d   = slot_q;
    slot_rn1 = {{(SLOT_W-1){1'b0}}, rn1_q};
    is_arb   = (bus.tag_state == TAG_ARBITRATE);
    is_rep   = (bus.tag_state == TAG_REPLY);
    for (int i = 0; i < SLOT_W; i++) begin
      q_mask[i] = (i < 32'(bus.q_val));
    end
    if (bus.slot_cmd_vld) begin
      case (bus.slot_cmd)
        CMD_QUERY: slot_d = lfsr_q[SLOT_W-1:0] & q_mask;
        CMD_QUERYREP: begin
          if ((is_arb || is_rep) && (slot_q != '0)) slot_d = slot_q - SLOT_W'(1);
        end
        CMD_DIVIDE: begin
          if (is_arb) begin
            if (!bus.divide_position) begin
              if (slot_q == '0)       slot_d = slot_rn1;
              else if (slot_q != '1)  slot_d = slot_q + SLOT_W'(1);
            end else if (slot_q == SLOT_W'(1)) begin
              slot_d = slot_rn1;
            end
          end else if (is_rep && !bus.divide_position) begin
            slot_d = slot_rn1;
          end
        end
        CMD_DISPERSE: begin
          if (is_arb) begin
            if (slot_q == '0)            slot_d = slot_rn1;
            else if (!slot_q[SLOT_W-1])  slot_d = {slot_q[SLOT_W-2:0], rn1_q};
            else                         slot_d = '1;
          end else if (is_rep) begin
            slot_d = slot_rn1;
          end
        end
        CMD_SHRINK: begin
          if (is_arb)      slot_d = slot_q >> 1;
          else if (is_rep) slot_d = '0;
        end
        default: slot_d = slot_q;
      endcase
    end
  end

  always_ff @(posedge DOUB_BLF) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED_VAL;
      cnt_q    <= '0;
      kind_q   <= '0;
      rn1_q    <= 1'b0;
      rn16_q   <= '0;
      handle_q <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      rn1_q    <= rn1_d;
      rn16_q   <= rn16_d;
      handle_q <= handle_d;
      slot_q   <= slot_d;
    end
  end

  assign bus.rn_busy   = (state_q != ST_IDLE);
  assign bus.rn_done   = (state_q == ST_DONE);
  assign bus.rn1       = rn1_q;
  assign bus.rn16      = rn16_q;
  assign bus.handle    = handle_q;
  assign bus.slot_val  = slot_q;
  assign bus.slot_zero = (slot_q == '0);

endmodule

// File: tb/tb_rng_slot_gen.sv
// Scoreboard bench for rng_slot_gen: stimulus tasks push expectations, monitors
// pop them on rn_done and on the cycle after each slot command.
module tb_rng_slot_gen;

  localparam logic [15:0] SEED  = 16'h29A1;
  localparam logic [3:0]  ARB   = 4'd1;
  localparam logic [3:0]  REP   = 4'd2;
  localparam logic [3:0]  OTHER = 4'd0;
  localparam logic [2:0]  QRY = 3'b000, QREP = 3'b001, DIV = 3'b010,
                          DISP = 3'b011, SHR = 3'b100, RSV = 3'b111;

  typedef struct {
    logic        rn1;
    logic [15:0] rn16;
    logic [15:0] handle;
  } rn_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  rn_exp_t     rn_q[$];
  logic [14:0] slot_exp_q[$];
  logic        slot_seen = 1'b0;

  logic [15:0] mlfsr = SEED;
  logic        exp_rn1 = 1'b0;
  logic [15:0] exp_rn16 = '0;
  logic [15:0] exp_handle = '0;

  rng_slot_gen_if #(.LFSR_W(16), .SLOT_W(15)) bus ();

  rng_slot_gen #(.LFSR_W(16), .SLOT_W(15)) dut (
    .DOUB_BLF (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[14] ^ x[13] ^ x[12]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_rn(input logic [1:0] kind);
    rn_exp_t e;
    int n;
    n = (kind == 2'b00) ? 1 : 16;
    for (int i = 0; i < n; i++) mlfsr = step(mlfsr);
    if (kind == 2'b00)      exp_rn1    = mlfsr[15];
    else if (kind == 2'b01) exp_rn16   = mlfsr;
    else                    exp_handle = mlfsr;
    e.rn1 = exp_rn1;
    e.rn16 = exp_rn16;
    e.handle = exp_handle;
    rn_q.push_back(e);
  endtask

  // poke fires a second rn_req mid-generation, which must be ignored
  task automatic issue_rn(input logic [1:0] kind, input bit poke);
    int n, busy_cnt, done_at;
    n = (kind == 2'b00) ? 1 : 16;
    busy_cnt = 0;
    done_at = -1;
    @(negedge clk);
    push_rn(kind);
    bus.rn_req = 1'b1;
    bus.rn_kind = kind;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.rn_req = 1'b0;
      if (poke && k == 3) begin
        bus.rn_req = 1'b1;
        bus.rn_kind = 2'b00;
      end
      if (bus.rn_busy) busy_cnt++;
      if (bus.rn_done) begin
        done_at = k;
        break;
      end
    end
    check("rn_latency", done_at, n + 1);
    check("rn_busy_cycles", busy_cnt, n + 1);
    @(negedge clk);
    check("rn_busy_after_done", bus.rn_busy, 0);
  endtask

  task automatic do_seed(input logic [15:0] val);
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed = val;
    mlfsr = (val == 16'h0) ? SEED : val;
    @(negedge clk);
    bus.seed_load = 1'b0;
  endtask

  task automatic do_slot(input logic [2:0] cmd, input logic [3:0] q, input logic pos,
                         input logic [3:0] tag, input logic [14:0] exp);
    @(negedge clk);
    bus.slot_cmd_vld = 1'b1;
    bus.slot_cmd = cmd;
    bus.q_val = q;
    bus.divide_position = pos;
    bus.tag_state = tag;
    slot_exp_q.push_back(exp);
    @(negedge clk);
    bus.slot_cmd_vld = 1'b0;
  endtask

  always @(negedge clk) begin : rn_monitor
    rn_exp_t e;
    if (!rst && bus.rn_done) begin
      if (rn_q.size() == 0) begin
        check("rn_done_unexpected", 1, 0);
      end else begin
        e = rn_q.pop_front();
        check("rn1", bus.rn1, e.rn1);
        check("rn16", bus.rn16, e.rn16);
        check("handle", bus.handle, e.handle);
      end
    end
  end

  always @(posedge clk) slot_seen <= bus.slot_cmd_vld && !rst;

  always @(negedge clk) begin : slot_monitor
    logic [14:0] e;
    if (slot_seen) begin
      if (slot_exp_q.size() == 0) begin
        check("slot_unexpected", 1, 0);
      end else begin
        e = slot_exp_q.pop_front();
        check("slot_val", bus.slot_val, e);
        check("slot_zero", bus.slot_zero, e == 15'h0);
      end
    end
  end

  initial begin
    int cnt;
    bus.seed_load = 1'b0;
    bus.seed = '0;
    bus.rn_req = 1'b0;
    bus.rn_kind = 2'b00;
    bus.slot_cmd_vld = 1'b0;
    bus.slot_cmd = 3'b000;
    bus.q_val = 4'd0;
    bus.divide_position = 1'b0;
    bus.tag_state = OTHER;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.rn_busy, 0);
    check("reset_done", bus.rn_done, 0);
    check("reset_rn1", bus.rn1, 0);
    check("reset_rn16", bus.rn16, 0);
    check("reset_handle", bus.handle, 0);
    check("reset_slot", bus.slot_val, 0);
    check("reset_slot_zero", bus.slot_zero, 1);

    issue_rn(2'b01, 1'b1);

    do_seed(16'h0000);
    issue_rn(2'b00, 1'b0);
    check("rn1_from_seed", bus.rn1, 0);
    issue_rn(2'b00, 1'b0);
    check("rn1_second_step", bus.rn1, 1);
    issue_rn(2'b10, 1'b0);

    @(negedge clk);
    bus.rn_req = 1'b1;
    bus.rn_kind = 2'b11;
    @(negedge clk);
    bus.rn_req = 1'b0;
    check("reserved_kind_idle", bus.rn_busy, 0);

    @(negedge clk);
    bus.rn_req = 1'b1;
    bus.rn_kind = 2'b01;
    repeat (5) begin
      @(negedge clk);
      bus.rn_req = 1'b0;
    end
    check("gen_busy_before_abort", bus.rn_busy, 1);
    bus.seed_load = 1'b1;
    bus.seed = 16'hBEEF;
    mlfsr = 16'hBEEF;
    @(negedge clk);
    bus.seed_load = 1'b0;
    check("abort_idle", bus.rn_busy, 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rn_done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_rn16_hold", bus.rn16, exp_rn16);

    do_slot(QRY, 4'd4, 1'b0, ARB, 15'h000F);
    do_slot(QRY, 4'd0, 1'b0, ARB, 15'h0000);
    do_slot(QRY, 4'd15, 1'b0, OTHER, 15'h3EEF);
    do_slot(QRY, 4'd8, 1'b0, REP, 15'h00EF);

    do_seed(16'h4001);
    do_slot(QRY, 4'd15, 1'b0, ARB, 15'h4001);
    do_slot(DISP, 4'd0, 1'b0, ARB, 15'h7FFF);
    do_slot(DIV, 4'd0, 1'b0, ARB, 15'h7FFF);
    do_slot(QREP, 4'd0, 1'b0, ARB, 15'h7FFE);
    do_slot(QREP, 4'd0, 1'b0, OTHER, 15'h7FFE);
    do_slot(RSV, 4'd0, 1'b0, ARB, 15'h7FFE);

    do_seed(16'h0006);
    do_slot(QRY, 4'd15, 1'b0, ARB, 15'h0006);
    do_slot(SHR, 4'd0, 1'b0, ARB, 15'h0003);
    do_slot(DISP, 4'd0, 1'b0, ARB, 15'h0007);
    do_slot(DIV, 4'd0, 1'b1, ARB, 15'h0007);
    do_slot(SHR, 4'd0, 1'b0, REP, 15'h0000);
    do_slot(QREP, 4'd0, 1'b0, ARB, 15'h0000);
    do_slot(DIV, 4'd0, 1'b0, ARB, 15'h0001);
    do_slot(QREP, 4'd0, 1'b0, REP, 15'h0000);
    do_slot(DIV, 4'd0, 1'b0, REP, 15'h0001);
    do_slot(QREP, 4'd0, 1'b0, ARB, 15'h0000);
    do_slot(DISP, 4'd0, 1'b0, REP, 15'h0001);
    do_slot(DIV, 4'd0, 1'b0, ARB, 15'h0002);
    do_slot(QRY, 4'd0, 1'b0, ARB, 15'h0000);

    // slot command sampled on the same edge that captures the new rn1 (0)
    @(negedge clk);
    push_rn(2'b00);
    bus.rn_req = 1'b1;
    bus.rn_kind = 2'b00;
    @(negedge clk);
    bus.rn_req = 1'b0;
    bus.slot_cmd_vld = 1'b1;
    bus.slot_cmd = DIV;
    bus.divide_position = 1'b0;
    bus.tag_state = ARB;
    slot_exp_q.push_back(15'h0001);
    @(negedge clk);
    bus.slot_cmd_vld = 1'b0;
    check("same_edge_done", bus.rn_done, 1);
    @(negedge clk);
    do_slot(DIV, 4'd0, 1'b0, REP, 15'h0000);

    @(negedge clk);
    bus.rn_req = 1'b1;
    bus.rn_kind = 2'b01;
    repeat (3) begin
      @(negedge clk);
      bus.rn_req = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mlfsr = SEED;
    exp_rn1 = 1'b0;
    exp_rn16 = '0;
    exp_handle = '0;
    check("midgen_rst_busy", bus.rn_busy, 0);
    check("midgen_rst_done", bus.rn_done, 0);
    check("midgen_rst_rn1", bus.rn1, 0);
    check("midgen_rst_rn16", bus.rn16, 0);
    check("midgen_rst_handle", bus.handle, 0);
    check("midgen_rst_slot", bus.slot_val, 0);
    repeat (20) @(negedge clk);
    issue_rn(2'b01, 1'b0);

    repeat (3) @(negedge clk);
    check("rn_queue_drained", rn_q.size(), 0);
    check("slot_queue_drained", slot_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
